// File: rtl/mc_bus_bridge_pkg.sv
// Shared definitions for the MCU parallel-bus bridge and the register file behind it.
package bp_bus_pkg;

    localparam int DEF_MC_DATA_WIDTH = 16;
    localparam int DEF_MC_ADD_WIDTH  = 6;

    localparam logic [15:0] RD_BAD_VALUE = 16'hFFFF;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } rd_state_e;

    // Register map entries the bridge and register file agree on
    localparam logic [5:0] ADDR_FIFO  = 6'h00;
    localparam logic [5:0] ADDR_SPEED = 6'h19;
    localparam logic [5:0] ADDR_MODE  = 6'h1a;

endpackage

// File: rtl/mc_bus_bridge_if.sv
// Register-side bus between the bridge (master) and the register file / status logic (slave).
interface mc_bus_bridge_if
    import bp_bus_pkg::*;
#(
    parameter int MC_DATA_WIDTH = DEF_MC_DATA_WIDTH,
    parameter int MC_ADD_WIDTH  = DEF_MC_ADD_WIDTH
);
    logic                     wr_stb;
    logic [MC_ADD_WIDTH-1:0]  wr_add;
    logic [MC_DATA_WIDTH-1:0] wr_data;
    logic                     rd_stb;
    logic [MC_ADD_WIDTH-1:0]  rd_add;
    logic                     rd_ack;
    logic [MC_DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_stb, wr_add, wr_data, rd_stb, rd_add,
        input  rd_ack, rd_data
    );

    modport slave (
        input  wr_stb, wr_add, wr_data, rd_stb, rd_add,
        output rd_ack, rd_data
    );
endinterface

// File: rtl/mc_bus_bridge_sync_fall.sv
// Strobe synchronizer with falling-edge pulse; arms only after a real high sample post-reset.
module sync_fall #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   prev_q;
    logic                   armed_q;

    // vld_pipe marks when sync_q's output holds a genuine post-reset sample, so the
    // reset-to-1 fill cannot arm a strobe that is actually held low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q   <= '1;
            vld_pipe <= '0;
            prev_q   <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
            prev_q   <= sync_q[SYNC_STAGES-1];
            if (vld_pipe[SYNC_STAGES-1] && sync_q[SYNC_STAGES-1])
                armed_q <= 1'b1;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign fall     = armed_q & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mc_bus_bridge.sv
// MCU async parallel bus to single-clock write strobes and handshaked reads.
module mc_bus_bridge
    import bp_bus_pkg::*;
#(
    parameter int MC_DATA_WIDTH = DEF_MC_DATA_WIDTH,
    parameter int MC_ADD_WIDTH  = DEF_MC_ADD_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int RD_TIMEOUT    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_oe,
    input  logic                     mc_we,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
    output logic [MC_DATA_WIDTH-1:0] mc_data_out,
    output logic                     mc_data_oe,
    mc_bus_bridge_if.master          rbus,
    output logic                     bus_err
);
    localparam logic [3:0] TMO_LAST = 4'(RD_TIMEOUT - 1);

    logic we_s, oe_s, ce_s;
    logic we_fall, oe_fall, ce_fall;

    sync_fall #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (
        .clock(clock), .reset(reset), .async_in(mc_we), .sync_out(we_s), .fall(we_fall)
    );
    sync_fall #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .clock(clock), .reset(reset), .async_in(mc_oe), .sync_out(oe_s), .fall(oe_fall)
    );
    sync_fall #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
        .clock(clock), .reset(reset), .async_in(mc_ce), .sync_out(ce_s), .fall(ce_fall)
    );

    rd_state_e  state;
    logic [3:0] tmo_cnt;
    logic       viol, viol_on, wr_go, rd_go, tmo_hit;

    // A violation is reported once, on the strobe edge that completes the WE+OE+CE overlap
    assign viol    = ~we_s & ~oe_s & ~ce_s;
    assign viol_on = viol & (we_fall | oe_fall | ce_fall);
    assign wr_go   = we_fall & ~ce_s & oe_s;
    assign rd_go   = oe_fall & ~ce_s & we_s;
    assign tmo_hit = (state == RD_WAIT) & ~rbus.rd_ack & (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RD_IDLE;
            tmo_cnt      <= '0;
            mc_data_out  <= '0;
            mc_data_oe   <= 1'b0;
            bus_err      <= 1'b0;
            rbus.wr_stb  <= 1'b0;
            rbus.wr_add  <= '0;
            rbus.wr_data <= '0;
            rbus.rd_stb  <= 1'b0;
            rbus.rd_add  <= '0;
        end else begin
            rbus.wr_stb <= wr_go;
            if (wr_go) begin
                rbus.wr_add  <= mc_add;
                rbus.wr_data <= mc_data_in;
            end
            rbus.rd_stb <= 1'b0;
            bus_err     <= viol_on | tmo_hit;
            mc_data_oe  <= ~oe_s & ~ce_s;

            case (state)
                RD_IDLE: begin
                    if (rd_go) begin
                        rbus.rd_add <= mc_add;
                        rbus.rd_stb <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rbus.rd_ack) begin
                        mc_data_out <= rbus.rd_data;
                        state       <= RD_DRIVE;
                    end else if (tmo_hit) begin
                        mc_data_out <= MC_DATA_WIDTH'(RD_BAD_VALUE);
                        state       <= RD_DRIVE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                RD_DRIVE: begin
                    if (oe_s || ce_s)
                        state <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule
